// File: rtl/io_uart_hub_pkg.sv
// Shared constants and types for the IO hub: address decode bits,
// status word layout and the UART serializer state encoding.
package io_pkg;
    // One-hot word-address bits (word address = io_addr[15:2])
    localparam int IO_LEDS_BIT = 0;
    localparam int IO_UART_BIT = 1;
    localparam int IO_STAT_BIT = 2;
    localparam int IO_HALT_BIT = 3;

    // Status word layout
    localparam int ST_BUSY_BIT    = 9;
    localparam int ST_DRAINED_BIT = 10;
    localparam int ST_OVF_LSB     = 16;
    localparam int ST_CNT_LSB     = 24;

    typedef enum logic [1:0] {
        SER_IDLE  = 2'd0,
        SER_START = 2'd1,
        SER_DATA  = 2'd2,
        SER_STOP  = 2'd3
    } ser_state_e;
endpackage

// File: rtl/io_uart_hub_if.sv
// CPU-side IO bus bundle: one write strobe, address, write data and
// read data lane per CPU port.
interface io_uart_hub_if #(parameter int NPORTS = 2);
    logic [NPORTS-1:0]       io_wr;
    logic [NPORTS-1:0][31:0] io_addr;
    logic [NPORTS-1:0][31:0] io_wdata;
    logic [NPORTS-1:0][31:0] io_rdata;

    modport master (output io_wr, io_addr, io_wdata, input io_rdata);
    modport slave  (input io_wr, io_addr, io_wdata, output io_rdata);
endinterface

// File: rtl/io_uart_hub_ser.sv
// 8N1 UART serializer. Takes a byte through a valid/ready handshake and
// shifts it out LSB first; a new byte can be taken in the last STOP cycle
// so consecutive frames run without an idle gap.
module uart_serializer import io_pkg::*; #(
    parameter int DIV = 10
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       valid,
    output logic       ready,
    input  logic [7:0] data,
    output logic       tx,
    output logic       idle
);
    localparam int BW = $clog2(DIV);

    ser_state_e    state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          baud_end;

    assign baud_end = (baud_q == BW'(DIV - 1));

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= SER_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            SER_IDLE:  if (valid) state_d = SER_START;
            SER_START: if (baud_end) state_d = SER_DATA;
            SER_DATA:  if (baud_end && bit_q == 3'd7) state_d = SER_STOP;
            SER_STOP:  if (baud_end) state_d = valid ? SER_START : SER_IDLE;
            default:   state_d = SER_IDLE;
        endcase
    end

    // Outputs: tx is decoded from state so reset forces the line high at once
    always_comb begin
        ready = (state_q == SER_IDLE) || (state_q == SER_STOP && baud_end);
        idle  = (state_q == SER_IDLE);
        case (state_q)
            SER_START: tx = 1'b0;
            SER_DATA:  tx = shreg_q[bit_q];
            default:   tx = 1'b1;
        endcase
    end

    // Baud/bit counters and shift register next values
    always_comb begin
        baud_d  = baud_end ? '0 : baud_q + BW'(1);
        bit_d   = bit_q;
        shreg_d = shreg_q;
        if (state_q == SER_IDLE) baud_d = '0;
        if (state_q == SER_DATA && baud_end) bit_d = bit_q + 3'd1;
        if (valid && ready) shreg_d = data;
    end

    // Datapath registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
        end else begin
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
        end
    end
endmodule

// File: rtl/io_uart_hub.sv
// Memory-mapped IO hub: LED register, shared UART TX FIFO fed by all CPU
// ports, status readback and halt that waits for the UART to drain.
module io_uart_hub import io_pkg::*; #(
    parameter int NPORTS      = 2,
    parameter int FIFO_DEPTH  = 16,
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int BAUD_RATE   = 230400
) (
    input  logic          clk,
    input  logic          resetn,
    io_uart_hub_if.slave  io,
    output logic [7:0]    leds,
    output logic          uart_tx,
    output logic          halt
);
    localparam int DIV = CLK_FREQ_HZ / BAUD_RATE;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    ovf_q, ovf_d;
    logic [7:0]    leds_q, leds_d;
    logic          halt_req_q, halt_req_d;
    logic          halt_q, halt_d;

    logic [CW-1:0]               free_slots, n_push;
    logic [NPORTS-1:0]           push_en;
    logic [NPORTS-1:0][AW-1:0]   push_idx;
    logic                        ser_ready, ser_idle, pop, drained;
    logic [7:0]                  head;
    logic [31:0]                 status;
    logic                        unused_io;

    assign free_slots = CW'(FIFO_DEPTH) - cnt_q;
    assign head       = mem_q[rptr_q];
    assign pop        = (cnt_q != '0) && ser_ready;
    assign drained    = (cnt_q == '0) && ser_idle;
    assign leds       = leds_q;
    assign halt       = halt_q;
    assign unused_io  = ^{io.io_addr, io.io_wdata};

    // Multi-port push: ports claim free slots in ascending order; the rest drop
    always_comb begin
        n_push   = '0;
        ovf_d    = ovf_q;
        push_en  = '0;
        push_idx = '0;
        for (int p = 0; p < NPORTS; p++) begin
            if (io.io_wr[p] && io.io_addr[p][2+IO_UART_BIT]) begin
                if (n_push < free_slots) begin
                    push_en[p]  = 1'b1;
                    push_idx[p] = wptr_q + n_push[AW-1:0];
                    n_push      = n_push + CW'(1);
                end else if (ovf_d != 8'hFF) begin
                    ovf_d = ovf_d + 8'd1;
                end
            end
        end
        // A pop only frees its slot from the next cycle, so free_slots uses cnt_q
        cnt_d  = cnt_q + n_push - CW'(pop);
        wptr_d = wptr_q + n_push[AW-1:0];
        rptr_d = rptr_q + AW'(pop);
    end

    // LED / halt decode; iterate high-to-low so the lowest port wins
    always_comb begin
        leds_d     = leds_q;
        halt_req_d = halt_req_q;
        for (int p = NPORTS - 1; p >= 0; p--) begin
            if (io.io_wr[p] && io.io_addr[p][2+IO_LEDS_BIT]) leds_d = io.io_wdata[p][7:0];
            if (io.io_wr[p] && io.io_addr[p][2+IO_HALT_BIT]) halt_req_d = 1'b1;
        end
        halt_d = halt_q | (halt_req_q & drained);
    end

    // Status word and per-port read mux
    always_comb begin
        status                      = '0;
        status[ST_BUSY_BIT]         = (free_slots < CW'(NPORTS));
        status[ST_DRAINED_BIT]      = drained;
        status[ST_OVF_LSB +: 8]     = ovf_q;
        status[ST_CNT_LSB +: 8]     = 8'(cnt_q);
        for (int p = 0; p < NPORTS; p++)
            io.io_rdata[p] = io.io_addr[p][2+IO_STAT_BIT] ? status : 32'd0;
    end

    // Control registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
            ovf_q      <= '0;
            leds_q     <= '0;
            halt_req_q <= 1'b0;
            halt_q     <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            leds_q     <= leds_d;
            halt_req_q <= halt_req_d;
            halt_q     <= halt_d;
        end
    end

    // FIFO storage; contents need no reset since cnt_q gates every read
    always_ff @(posedge clk) begin
        for (int p = 0; p < NPORTS; p++)
            if (push_en[p]) mem_q[push_idx[p]] <= io.io_wdata[p][7:0];
    end

    uart_serializer #(.DIV(DIV)) u_ser (
        .clk    (clk),
        .resetn (resetn),
        .valid  (cnt_q != '0),
        .ready  (ser_ready),
        .data   (head),
        .tx     (uart_tx),
        .idle   (ser_idle)
    );
endmodule

// File: tb/tb_io_uart_hub.sv
// Directed bench for io_uart_hub: expected UART bytes are queued when
// written and checked by a frame decoder watching uart_tx.
module tb_io_uart_hub;
    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] leds;
    logic       uart_tx;
    logic       halt;

    io_uart_hub_if #(.NPORTS(2)) bus ();

    io_uart_hub #(.NPORTS(2), .FIFO_DEPTH(4), .CLK_FREQ_HZ(1000), .BAUD_RATE(100)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .io      (bus.slave),
        .leds    (leds),
        .uart_tx (uart_tx),
        .halt    (halt)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] A_LEDS = 32'h04, A_UART = 32'h08, A_STAT = 32'h10, A_HALT = 32'h20;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame decoder: samples mid-bit on the falling clock edge
    int         cyc = 0, rx_cnt = 0, last_start = 0, prev_start = 0;
    logic       rx_act = 1'b0;
    logic [7:0] rx_sh = '0;
    always @(negedge clk) begin
        cyc++;
        if (!resetn) begin
            rx_act = 1'b0;
        end else if (!rx_act) begin
            if (uart_tx === 1'b0) begin
                rx_act = 1'b1; rx_cnt = 0;
                prev_start = last_start; last_start = cyc;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt == 5) chk("rx_start", {31'd0, uart_tx}, 32'd0);
            else if (rx_cnt > 5 && rx_cnt < 95 && rx_cnt % 10 == 5) rx_sh = {uart_tx, rx_sh[7:1]};
            else if (rx_cnt == 95) begin
                chk("rx_stop", {31'd0, uart_tx}, 32'd1);
                if (exp_q.size() == 0) chk("rx_unexpected", {24'd0, rx_sh}, 32'hFFFF_FFFF);
                else chk("rx_byte", {24'd0, rx_sh}, {24'd0, exp_q.pop_front()});
                rx_act = 1'b0;
            end
        end
    end

    // One bus cycle on both ports; st captures port0 read data before the edge
    task automatic drive(input logic [1:0] wr, input logic [31:0] a0, input logic [31:0] d0,
                         input logic [31:0] a1, input logic [31:0] d1, output logic [31:0] st);
        bus.io_wr = wr;
        bus.io_addr[0] = a0; bus.io_wdata[0] = d0;
        bus.io_addr[1] = a1; bus.io_wdata[1] = d1;
        #1 st = bus.io_rdata[0];
        @(posedge clk); #1;
        bus.io_wr = '0;
    endtask

    task automatic rd_status(output logic [31:0] s);
        bus.io_addr[0] = A_STAT; bus.io_addr[1] = A_STAT;
        #1 s = bus.io_rdata[0];
    endtask

    task automatic wait_drained(input int budget);
        logic [31:0] s;
        int n = 0;
        do begin @(negedge clk); rd_status(s); n++; end while (!s[10] && n < budget);
        chk("drain_wait", {31'd0, s[10]}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] s, st;
        logic [7:0]  b;
        int d_cyc, h_cyc, qleft;
        logic early;
        bus.io_wr = '0; bus.io_addr = '0; bus.io_wdata = '0;

        // Reset state
        #12;
        rd_status(s);
        chk("rst_leds", {24'd0, leds}, 32'd0);
        chk("rst_tx", {31'd0, uart_tx}, 32'd1);
        chk("rst_halt", {31'd0, halt}, 32'd0);
        chk("rst_status", s, 32'h0000_0400);
        chk("rst_status_p1", bus.io_rdata[1], 32'h0000_0400);
        resetn = 1'b1;
        @(posedge clk); #1;

        // 1: single char 0x41 with exact line waveform
        b = 8'h41; exp_q.push_back(b);
        drive(2'b01, A_UART, 32'h41, 32'd0, 32'd0, st);
        for (int n = 1; n <= 101; n++) begin
            logic e;
            @(negedge clk);
            if (n == 1) e = 1'b1;
            else if (n <= 11) e = 1'b0;
            else if (n <= 91) e = b[(n - 12) / 10];
            else e = 1'b1;
            chk($sformatf("t1_tx_c%0d", n), {31'd0, uart_tx}, {31'd0, e});
            if (n == 101) begin rd_status(s); chk("t1_drained_c101", {31'd0, s[10]}, 32'd0); end
        end
        @(negedge clk); rd_status(s);
        chk("t1_drained_c102", {31'd0, s[10]}, 32'd1);

        // 2: two ports same cycle, back-to-back frames
        @(posedge clk); #1;
        exp_q.push_back(8'h61); exp_q.push_back(8'h62);
        drive(2'b11, A_UART, 32'h61, A_UART, 32'h62, st);
        @(negedge clk); rd_status(s);
        chk("t2_cnt_c1", {24'd0, s[31:24]}, 32'd2);
        @(negedge clk); rd_status(s);
        chk("t2_cnt_c2", {24'd0, s[31:24]}, 32'd1);
        wait_drained(400);
        chk("t2_ovf", {24'd0, s[23:16]}, 32'd0);
        chk("t2_gap", last_start - prev_start, 32'd100);
        chk("t2_queue_empty", exp_q.size(), 32'd0);

        // 3: six chars in three cycles into a depth-4 FIFO; the first pop
        //    lands after cycle 1, so only 0x66 finds no room
        @(posedge clk); #1;
        for (int k = 8'h61; k <= 8'h65; k++) exp_q.push_back(8'(k));
        drive(2'b11, A_UART | A_STAT, 32'h61, A_UART, 32'h62, st);
        chk("t3_st_c0", st, 32'h0000_0400);
        drive(2'b11, A_UART | A_STAT, 32'h63, A_UART, 32'h64, st);
        chk("t3_st_c1", st, 32'h0200_0000);
        drive(2'b11, A_UART | A_STAT, 32'h65, A_UART, 32'h66, st);
        chk("t3_st_c2", st, 32'h0300_0200);
        rd_status(s);
        chk("t3_st_after", s, 32'h0401_0200);
        wait_drained(800);
        chk("t3_ovf_final", {24'd0, s[23:16]}, 32'd1);
        chk("t3_queue_empty", exp_q.size(), 32'd0);

        // 4: LED priority
        @(posedge clk); #1;
        drive(2'b11, A_LEDS, 32'h0F, A_LEDS, 32'hF0, st);
        chk("t4_leds_both", {24'd0, leds}, 32'h0F);
        drive(2'b10, 32'd0, 32'd0, A_LEDS, 32'hF0, st);
        chk("t4_leds_p1", {24'd0, leds}, 32'hF0);

        // 5: deferred halt
        exp_q.push_back(8'h31); exp_q.push_back(8'h32); exp_q.push_back(8'h33);
        drive(2'b01, A_UART, 32'h31, 32'd0, 32'd0, st);
        drive(2'b01, A_UART, 32'h32, 32'd0, 32'd0, st);
        drive(2'b01, A_UART, 32'h33, 32'd0, 32'd0, st);
        drive(2'b01, A_HALT, 32'h1, 32'd0, 32'd0, st);
        d_cyc = -1; h_cyc = -1; early = 1'b0; qleft = -1;
        for (int c = 0; c < 600 && h_cyc < 0; c++) begin
            @(negedge clk); rd_status(s);
            if (halt && d_cyc < 0) early = 1'b1;
            if (halt && h_cyc < 0) h_cyc = c;
            if (s[10] && d_cyc < 0) begin d_cyc = c; qleft = exp_q.size(); end
        end
        chk("t5_no_early_halt", {31'd0, early}, 32'd0);
        chk("t5_frames_done", qleft, 32'd0);
        chk("t5_halt_seen", {31'd0, h_cyc >= 0}, 32'd1);
        chk("t5_halt_delay", h_cyc - d_cyc, 32'd1);
        repeat (20) @(negedge clk);
        chk("t5_halt_sticky", {31'd0, halt}, 32'd1);

        // 6: reset in the middle of DATA, then a clean frame
        @(posedge clk); #1;
        drive(2'b01, A_UART, 32'h41, 32'd0, 32'd0, st);
        repeat (40) @(posedge clk);
        chk("t6_pre_tx_active", {31'd0, rx_act}, 32'd1);
        bus.io_addr[0] = A_STAT;
        #2 resetn = 1'b0;
        #1;
        chk("t6_rst_tx", {31'd0, uart_tx}, 32'd1);
        chk("t6_rst_halt", {31'd0, halt}, 32'd0);
        chk("t6_rst_cnt", {24'd0, bus.io_rdata[0][31:24]}, 32'd0);
        repeat (2) @(negedge clk);
        @(posedge clk); #1 resetn = 1'b1;
        @(posedge clk); #1;
        exp_q.push_back(8'h55);
        drive(2'b01, A_UART, 32'h55, 32'd0, 32'd0, st);
        wait_drained(400);
        chk("t6_queue_empty", exp_q.size(), 32'd0);
        chk("t6_halt_low", {31'd0, halt}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
